// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO feeding an 8N1 serializer.
// Bit period comes from clk_div, clamped to a minimum of 4 clocks.
module uart_tx_ctrl #(
    parameter  int FIFO_DEPTH = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_en,
    input  logic [31:0]      clk_div,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level,
    output logic             uart_tx
);

    localparam int PW = LVL_W - 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [LVL_W-1:0] level_nx;
    logic [31:0]      period;
    logic [31:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             push;
    logic             pop;
    logic             bit_end;
    logic             fifo_ne;

    assign push    = wr_valid && wr_ready;
    assign fifo_ne = fifo_level != '0;
    assign bit_end = baud_cnt == period - 32'd1;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and pop decision; a finished stop bit may chain straight into a new start bit
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_en && fifo_ne) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (cfg_en && fifo_ne) begin
                        pop      = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        level_nx = fifo_level;
        unique case ({push, pop})
            2'b10:   level_nx = fifo_level + LVL_W'(1);
            2'b01:   level_nx = fifo_level - LVL_W'(1);
            default: level_nx = fifo_level;
        endcase
    end

    // FIFO storage; emptiness is tracked by the pointers and level, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, level and the status flags derived from it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            wr_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_level <= level_nx;
            wr_ready   <= level_nx != FULL;
            busy       <= (state_nx != IDLE) || (level_nx != '0);
        end
    end

    // Shift register, latched bit period, baud counter and bit index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift    <= '0;
            period   <= 32'd4;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (pop) begin
            shift    <= mem[rd_ptr];
            period   <= (clk_div < 32'd4) ? 32'd4 : clk_div;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (state == DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 32'd1;
            end
        end
    end

    // Line driver flop, one cycle behind the state so the line never glitches
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_tx <= 1'b1;
        end else begin
            unique case (state)
                START:   uart_tx <= 1'b0;
                DATA:    uart_tx <= shift[0];
                default: uart_tx <= 1'b1;
            endcase
        end
    end

endmodule
